l3_cache_ctrl: RTL



---
 rtl/l3_cache_ctrl_pkg.sv | 32 +++
 rtl/l3_cache_ctrl_slice_addr_gen.sv | 59 +++++
 rtl/l3_cache_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/l3_cache_ctrl_pkg.sv
// Shared encodings for the l3 cache controller: move directions, FSM states, payload widths.
package l3_cache_ctrl_pkg;

    localparam int unsigned MOVE_W  = 4;
    localparam int unsigned BLOCK_W = 5;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ST_W    = 2;

    localparam logic [MOVE_W-1:0] MOVE_PX = 4'b0001;
    localparam logic [MOVE_W-1:0] MOVE_NX = 4'b0010;
    localparam logic [MOVE_W-1:0] MOVE_PZ = 4'b0100;
    localparam logic [MOVE_W-1:0] MOVE_NZ = 4'b1000;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_SHIFT = 2'd1;
    localparam logic [ST_W-1:0] ST_REQ   = 2'd2;
    localparam logic [ST_W-1:0] ST_FILL  = 2'd3;

    function automatic logic move_is_legal(input logic [MOVE_W-1:0] m);
        return (m == MOVE_PX) || (m == MOVE_NX) || (m == MOVE_PZ) || (m == MOVE_NZ);
    endfunction

    function automatic logic move_is_x(input logic [MOVE_W-1:0] m);
        return m[0] | m[1];
    endfunction

    // Positive moves expose the far face of the cache.
    function automatic logic move_is_pos(input logic [MOVE_W-1:0] m);
        return m[0] | m[2];
    endfunction

endpackage

// File: rtl/l3_cache_ctrl_slice_addr_gen.sv
// Walks the voxels of a freshly exposed slice: y outer, in-plane axis inner, flags the last one.
module l3_slice_addr_gen
    import l3_cache_ctrl_pkg::*;
#(
    parameter int unsigned LENGTH = 64,
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      start_in,
    input  logic [MOVE_W-1:0]         dir_in,
    input  logic                      advance_in,
    output logic [$clog2(LENGTH)-1:0] x_out,
    output logic [$clog2(HEIGHT)-1:0] y_out,
    output logic [$clog2(WIDTH)-1:0]  z_out,
    output logic                      last_out
);

    localparam int unsigned XW = $clog2(LENGTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned ZW = $clog2(WIDTH);
    localparam int unsigned IW = (XW > ZW) ? XW : ZW;

    logic          x_move_q;
    logic          pos_q;
    logic [IW-1:0] inner_q;
    logic [YW-1:0] outer_q;
    logic [IW-1:0] inner_max;

    assign inner_max = x_move_q ? IW'(WIDTH - 1) : IW'(LENGTH - 1);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_move_q <= 1'b0;
            pos_q    <= 1'b0;
            inner_q  <= '0;
            outer_q  <= '0;
        end else if (start_in) begin
            x_move_q <= move_is_x(dir_in);
            pos_q    <= move_is_pos(dir_in);
            inner_q  <= '0;
            outer_q  <= '0;
        end else if (advance_in) begin
            if (inner_q == inner_max) begin
                inner_q <= '0;
                outer_q <= outer_q + YW'(1);
            end else begin
                inner_q <= inner_q + IW'(1);
            end
        end
    end

    assign x_out    = x_move_q ? (pos_q ? XW'(LENGTH - 1) : '0) : XW'(inner_q);
    assign z_out    = x_move_q ? ZW'(inner_q) : (pos_q ? ZW'(WIDTH - 1) : '0);
    assign y_out    = outer_q;
    assign last_out = (outer_q == YW'(HEIGHT - 1)) && (inner_q == inner_max);

endmodule

// File: rtl/l3_cache_ctrl.sv
// Move sequencer and read/write arbiter in front of l3_cache: shift, request slice, refill.
module l3_cache_ctrl
    import l3_cache_ctrl_pkg::*;
#(
    parameter int unsigned LENGTH       = 64,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [MOVE_W-1:0]         move_in,
    input  logic                      move_valid_in,
    output logic                      move_ready_out,
    input  logic [$clog2(LENGTH)-1:0] rd_x_in,
    input  logic [$clog2(HEIGHT)-1:0] rd_y_in,
    input  logic [$clog2(WIDTH)-1:0]  rd_z_in,
    input  logic                      rd_req_in,
    output logic                      rd_ready_out,
    output logic                      rd_valid_out,
    output logic [BLOCK_W-1:0]        rd_data_out,
    input  logic [BYTE_W-1:0]         ld_data_in,
    input  logic                      ld_valid_in,
    output logic                      ld_ready_out,
    output logic                      slice_req_out,
    output logic [MOVE_W-1:0]         slice_dir_out,
    output logic                      refill_busy_out,
    output logic [$clog2(LENGTH)-1:0] cache_xread_out,
    output logic [$clog2(HEIGHT)-1:0] cache_yread_out,
    output logic [$clog2(WIDTH)-1:0]  cache_zread_out,
    output logic [$clog2(LENGTH)-1:0] cache_xwrite_out,
    output logic [$clog2(HEIGHT)-1:0] cache_ywrite_out,
    output logic [$clog2(WIDTH)-1:0]  cache_zwrite_out,
    output logic [BYTE_W-1:0]         cache_data_out,
    output logic [MOVE_W-1:0]         cache_ctrl_out,
    output logic                      cache_trigger_out,
    output logic                      cache_valid_out,
    output logic                      cache_we_out,
    output logic                      cache_re_out,
    input  logic [BLOCK_W-1:0]        cache_block_in
);

    localparam int unsigned XW = $clog2(LENGTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned ZW = $clog2(WIDTH);

    logic [ST_W-1:0]         state_q, state_d;
    logic [MOVE_W-1:0]       move_q;
    logic                    last_wr_q;
    logic [READ_LATENCY-1:0] rd_pipe_q;
    logic                    rd_grant_c, wr_grant_c, move_take_c;
    logic [XW-1:0]           gen_x;
    logic [YW-1:0]           gen_y;
    logic [ZW-1:0]           gen_z;
    logic                    gen_last;

    assign move_take_c = (state_q == ST_IDLE) && move_valid_in && move_ready_out;

    l3_slice_addr_gen #(
        .LENGTH (LENGTH),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr_gen (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (state_q == ST_SHIFT),
        .dir_in     (move_q),
        .advance_in (wr_grant_c),
        .x_out      (gen_x),
        .y_out      (gen_y),
        .z_out      (gen_z),
        .last_out   (gen_last)
    );

    // One cache op per cycle; contention in FILL alternates from the last grant.
    always_comb begin
        rd_grant_c = 1'b0;
        wr_grant_c = 1'b0;
        if (!rst_in) begin
            if (state_q == ST_FILL) begin
                if (rd_req_in && ld_valid_in) begin
                    rd_grant_c = last_wr_q;
                    wr_grant_c = !last_wr_q;
                end else begin
                    rd_grant_c = rd_req_in;
                    wr_grant_c = ld_valid_in;
                end
            end else begin
                rd_grant_c = rd_req_in && (state_q != ST_SHIFT);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (move_take_c && move_is_legal(move_in)) state_d = ST_SHIFT;
            ST_SHIFT: state_d = ST_REQ;
            ST_REQ:   state_d = ST_FILL;
            ST_FILL:  if (wr_grant_c && gen_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Registered outputs are loaded from the next state so they line up with it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            move_q            <= '0;
            move_ready_out    <= 1'b0;
            cache_ctrl_out    <= '0;
            cache_trigger_out <= 1'b0;
            cache_valid_out   <= 1'b0;
            slice_req_out     <= 1'b0;
            slice_dir_out     <= '0;
            refill_busy_out   <= 1'b0;
            rd_pipe_q         <= '0;
            last_wr_q         <= 1'b1;
        end else begin
            if (move_take_c) move_q <= move_in;
            move_ready_out    <= (state_d == ST_IDLE);
            cache_ctrl_out    <= (state_d == ST_SHIFT) ? move_in : '0;
            cache_trigger_out <= (state_d == ST_SHIFT);
            cache_valid_out   <= (state_d == ST_SHIFT);
            slice_req_out     <= (state_d == ST_REQ);
            if (state_d == ST_REQ) slice_dir_out <= move_q;
            refill_busy_out   <= (state_d != ST_IDLE);
            rd_pipe_q[0]      <= rd_grant_c;
            for (int i = 1; i < int'(READ_LATENCY); i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
            if (rd_grant_c || wr_grant_c) last_wr_q <= wr_grant_c;
        end
    end

    assign rd_ready_out     = rd_grant_c;
    assign ld_ready_out     = wr_grant_c;
    assign cache_re_out     = rd_grant_c;
    assign cache_we_out     = wr_grant_c;
    assign cache_xread_out  = rd_grant_c ? rd_x_in : '0;
    assign cache_yread_out  = rd_grant_c ? rd_y_in : '0;
    assign cache_zread_out  = rd_grant_c ? rd_z_in : '0;
    assign cache_xwrite_out = wr_grant_c ? gen_x : '0;
    assign cache_ywrite_out = wr_grant_c ? gen_y : '0;
    assign cache_zwrite_out = wr_grant_c ? gen_z : '0;
    assign cache_data_out   = wr_grant_c ? ld_data_in : '0;
    assign rd_valid_out     = rd_pipe_q[READ_LATENCY-1];
    assign rd_data_out      = rd_valid_out ? cache_block_in : '0;

endmodule
